// File: rtl/colour_centroid_tracker_if.sv
// ============================================================================
// Module : colour_centroid_tracker_if
// Brief  : Pixel stream in, centroid results out, for colour_centroid_tracker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface colour_centroid_tracker_if #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 20
);
  logic [7:0]         R;
  logic [7:0]         G;
  logic [7:0]         B;
  logic               ActiveArea;
  logic [COORD_W-1:0] Hcnt;
  logic [COORD_W-1:0] Vcnt;
  logic signed [8:0]  thr_lo;
  logic signed [8:0]  thr_hi;

  logic               mask;
  logic [COORD_W-1:0] xpos;
  logic [COORD_W-1:0] ypos;
  logic               detected;
  logic [CNT_W-1:0]   pixel_count;
  logic               result_valid;
  logic               frame_dropped;
  logic               busy;

  modport master (
    output R, G, B, ActiveArea, Hcnt, Vcnt, thr_lo, thr_hi,
    input  mask, xpos, ypos, detected, pixel_count, result_valid, frame_dropped, busy
  );

  modport slave (
    input  R, G, B, ActiveArea, Hcnt, Vcnt, thr_lo, thr_hi,
    output mask, xpos, ypos, detected, pixel_count, result_valid, frame_dropped, busy
  );
endinterface

`default_nettype wire

// File: rtl/colour_centroid_tracker.sv
// ============================================================================
// Module : colour_centroid_tracker
// Brief  : R-G window pixel classifier with per-frame X/Y centroid divider.
//          Optional SMOOTH_ALPHA_EN enables exponential smoothing of xpos/ypos.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module colour_centroid_tracker #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int COORD_W    = 10,
  parameter int SUM_W      = 40,
  parameter int CNT_W      = 20,
  parameter int MIN_PIXELS = 64,
  parameter int SMOOTH_SH  = 2
) (
  input  wire logic                clock,
  input  wire logic                reset,
  colour_centroid_tracker_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_DIV_X = 2'd1;
  localparam logic [1:0] c_DIV_Y = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam int                 c_BW      = (COORD_W > 1) ? $clog2(COORD_W) : 1;
  localparam logic [c_BW-1:0]    c_bit_top = c_BW'(COORD_W - 1);
  localparam logic [c_BW-1:0]    c_bit_one = c_BW'(1);
  localparam logic [COORD_W-1:0] c_h_end   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] c_v_end   = COORD_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]   c_min     = CNT_W'(MIN_PIXELS);
  localparam logic [CNT_W-1:0]   c_one     = CNT_W'(1);

  // ---------------- classification ----------------
  logic signed [8:0] w_diff;
  logic              w_match;
  logic              w_hit;
  logic              w_at_end;
  logic              r_at_end_q;
  logic              w_frame_end;

  assign w_diff      = $signed({1'b0, bus.R}) - $signed({1'b0, bus.G});
  assign w_match     = (w_diff > $signed(bus.thr_lo)) && (w_diff < $signed(bus.thr_hi));
  assign w_hit       = bus.ActiveArea && (bus.Hcnt < c_h_end) && (bus.Vcnt < c_v_end) && w_match;
  assign w_at_end    = (bus.Hcnt == c_h_end) && (bus.Vcnt == c_v_end);
  assign w_frame_end = w_at_end && !r_at_end_q;

  // ---------------- accumulators ----------------
  logic [SUM_W-1:0] r_sum_x;
  logic [SUM_W-1:0] r_sum_y;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_at_end_q <= 1'b0;
      r_sum_x    <= '0;
      r_sum_y    <= '0;
      r_cnt      <= '0;
    end else begin
      r_at_end_q <= w_at_end;
      if (w_frame_end) begin
        r_sum_x <= '0;
        r_sum_y <= '0;
        r_cnt   <= '0;
      end else if (w_hit) begin
        r_sum_x <= r_sum_x + {{(SUM_W-COORD_W){1'b0}}, bus.Hcnt};
        r_sum_y <= r_sum_y + {{(SUM_W-COORD_W){1'b0}}, bus.Vcnt};
        r_cnt   <= r_cnt + c_one;
      end
    end
  end

  // ---------------- control FSM ----------------
  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [c_BW-1:0] r_bit;
  logic            r_skip;

  always_ff @(posedge clock) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (w_frame_end) w_state_next = (r_cnt >= c_min) ? c_DIV_X : c_DONE;
      c_DIV_X: if (r_bit == '0) w_state_next = c_DIV_Y;
      c_DIV_Y: if (r_bit == '0) w_state_next = c_DONE;
      default: w_state_next = c_IDLE;
    endcase
  end

  logic w_start;
  logic w_step;
  logic w_load_y;
  logic w_publish;
  logic w_drop;

  always_comb begin
    w_start   = (r_state == c_IDLE) && w_frame_end;
    w_step    = (r_state == c_DIV_X) || (r_state == c_DIV_Y);
    w_load_y  = (r_state == c_DIV_X) && (r_bit == '0);
    w_publish = (r_state == c_DONE);
    w_drop    = w_frame_end && (r_state != c_IDLE);
  end

  // ---------------- restoring divider ----------------
  // Quotient fits in COORD_W bits, so the divisor starts pre-shifted by
  // COORD_W-1 and walks right one place per cycle.
  logic [SUM_W-1:0]   r_rem;
  logic [SUM_W-1:0]   r_dsh;
  logic [SUM_W-1:0]   r_sum_y_snap;
  logic [CNT_W-1:0]   r_cnt_snap;
  logic [COORD_W-1:0] r_quo;
  logic [COORD_W-1:0] r_qx;
  logic               w_ge;
  logic [COORD_W-1:0] w_quo_next;
  logic [SUM_W-1:0]   w_dsh_acc;
  logic [SUM_W-1:0]   w_dsh_snap;

  assign w_ge       = (r_rem >= r_dsh);
  assign w_quo_next = {r_quo[COORD_W-2:0], w_ge};
  assign w_dsh_acc  = {{(SUM_W-CNT_W){1'b0}}, r_cnt} << (COORD_W - 1);
  assign w_dsh_snap = {{(SUM_W-CNT_W){1'b0}}, r_cnt_snap} << (COORD_W - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem        <= '0;
      r_dsh        <= '0;
      r_sum_y_snap <= '0;
      r_cnt_snap   <= '0;
      r_quo        <= '0;
      r_qx         <= '0;
      r_bit        <= '0;
      r_skip       <= 1'b0;
    end else if (w_start) begin
      r_rem        <= r_sum_x;
      r_dsh        <= w_dsh_acc;
      r_sum_y_snap <= r_sum_y;
      r_cnt_snap   <= r_cnt;
      r_skip       <= (r_cnt < c_min);
      r_bit        <= c_bit_top;
    end else if (w_step) begin
      r_quo <= w_quo_next;
      if (w_load_y) begin
        r_qx  <= w_quo_next;
        r_rem <= r_sum_y_snap;
        r_dsh <= w_dsh_snap;
        r_bit <= c_bit_top;
      end else begin
        if (w_ge) r_rem <= r_rem - r_dsh;
        r_dsh <= r_dsh >> 1;
        r_bit <= r_bit - c_bit_one;
      end
    end
  end

  // ---------------- result formatting ----------------
  logic [COORD_W-1:0] r_xpos;
  logic [COORD_W-1:0] r_ypos;
  logic [COORD_W-1:0] w_new_x;
  logic [COORD_W-1:0] w_new_y;
  logic               w_unused;

`ifdef SMOOTH_ALPHA_EN
  logic                     r_primed;
  logic signed [COORD_W:0]  w_dx;
  logic signed [COORD_W:0]  w_dy;
  logic signed [COORD_W:0]  w_fx;
  logic signed [COORD_W:0]  w_fy;

  assign w_dx     = $signed({1'b0, r_qx})  - $signed({1'b0, r_xpos});
  assign w_dy     = $signed({1'b0, r_quo}) - $signed({1'b0, r_ypos});
  assign w_fx     = $signed({1'b0, r_xpos}) + (w_dx >>> SMOOTH_SH);
  assign w_fy     = $signed({1'b0, r_ypos}) + (w_dy >>> SMOOTH_SH);
  assign w_new_x  = r_primed ? w_fx[COORD_W-1:0] : r_qx;
  assign w_new_y  = r_primed ? w_fy[COORD_W-1:0] : r_quo;
  assign w_unused = ^{bus.B, w_fx[COORD_W], w_fy[COORD_W]};

  always_ff @(posedge clock) begin
    if (reset)                     r_primed <= 1'b0;
    else if (w_publish && !r_skip) r_primed <= 1'b1;
  end
`else
  localparam int c_unused_sh = SMOOTH_SH;
  assign w_new_x  = r_qx;
  assign w_new_y  = r_quo;
  assign w_unused = ^bus.B;
`endif

  logic             r_mask;
  logic             r_detected;
  logic [CNT_W-1:0] r_pixel_count;
  logic             r_result_valid;
  logic             r_frame_dropped;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mask          <= 1'b0;
      r_xpos          <= '0;
      r_ypos          <= '0;
      r_detected      <= 1'b0;
      r_pixel_count   <= '0;
      r_result_valid  <= 1'b0;
      r_frame_dropped <= 1'b0;
    end else begin
      r_mask          <= bus.ActiveArea && w_match;
      r_result_valid  <= w_publish;
      r_frame_dropped <= w_drop;
      if (w_publish) begin
        r_pixel_count <= r_cnt_snap;
        r_detected    <= !r_skip;
        if (!r_skip) begin
          r_xpos <= w_new_x;
          r_ypos <= w_new_y;
        end
      end
    end
  end

  assign bus.mask          = r_mask;
  assign bus.xpos          = r_xpos;
  assign bus.ypos          = r_ypos;
  assign bus.detected      = r_detected;
  assign bus.pixel_count   = r_pixel_count;
  assign bus.result_valid  = r_result_valid;
  assign bus.frame_dropped = r_frame_dropped;
  assign bus.busy          = (r_state != c_IDLE);

endmodule

`default_nettype wire
